// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO pointer stages: Gray conversion and full-compare.
package fifo_pkg;

   localparam int FIFO_ADDR_WIDTH = 3;
   localparam int PTR_MAX_W       = 32;

   typedef logic [PTR_MAX_W-1:0] ptr_t;

   // Operands are zero-extended to PTR_MAX_W, so these work for any pointer width up to that.
   function automatic ptr_t bin2gray(input ptr_t b);
      return b ^ (b >> 1);
   endfunction

   function automatic ptr_t gray2bin(input ptr_t g);
      ptr_t b;
      b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
      for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Gray pointer a full write side must equal: read pointer with its top two bits inverted.
   function automatic ptr_t full_gray(input ptr_t g, input int aw);
      return g ^ (ptr_t'(3) << (aw - 1));
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for Gray pointers crossing clock domains; both stages reset to 0.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             wclk,
   input  logic             wrst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q1_q;
   logic [WIDTH-1:0] q2_q;

   always_ff @(posedge wclk) begin
      if (wrst) begin
         q1_q <= '0;
         q2_q <= '0;
      end else begin
         q1_q <= d;
         q2_q <= q1_q;
      end
   end

   assign q = q2_q;

endmodule

// File: rtl/wptr_full.sv
// Write-side pointer, full/overflow and (with FIFO_WLEVEL_EN) level/almost-full logic of the async FIFO.
// Macro FIFO_WLEVEL_EN builds wlevel/walmost_full; without it both outputs are tied to 0.
module wptr_full
   import fifo_pkg::*;
#(
   parameter int ADDR_WIDTH   = FIFO_ADDR_WIDTH,
   parameter int AFULL_THRESH = 6
) (
   input  logic                  wclk,
   input  logic                  wrst,
   input  logic                  winc,
   input  logic [ADDR_WIDTH:0]   rptr,
   output logic                  wen,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [ADDR_WIDTH:0]   wptr,
   output logic                  wfull,
   output logic                  walmost_full,
   output logic [ADDR_WIDTH:0]   wlevel,
   output logic                  woverflow
);

   localparam int PW    = ADDR_WIDTH + 1;
   localparam int DEPTH = 1 << ADDR_WIDTH;

   if (ADDR_WIDTH < 2 || AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_params
      $error("wptr_full: ADDR_WIDTH or AFULL_THRESH out of range");
   end

   logic [PW-1:0] wbin_q, wbin_d;
   logic [PW-1:0] wptr_q, wgray_d;
   logic [PW-1:0] rq2;
   logic          wfull_q, wfull_d;
   logic          wovf_q, wovf_d;
   logic          accept;

   sync_2ff #(.WIDTH(PW)) u_rsync (
      .wclk (wclk),
      .wrst (wrst),
      .d    (rptr),
      .q    (rq2)
   );

   always_comb begin
      accept  = winc & ~wfull_q;
      wbin_d  = wbin_q + PW'(accept);
      wgray_d = PW'(bin2gray(ptr_t'(wbin_d)));
      wfull_d = (wgray_d == PW'(full_gray(ptr_t'(rq2), ADDR_WIDTH)));
      wovf_d  = wovf_q | (winc & wfull_q);
   end

   always_ff @(posedge wclk) begin
      if (wrst) begin
         wbin_q  <= '0;
         wptr_q  <= '0;
         wfull_q <= 1'b0;
         wovf_q  <= 1'b0;
      end else begin
         wbin_q  <= wbin_d;
         wptr_q  <= wgray_d;
         wfull_q <= wfull_d;
         wovf_q  <= wovf_d;
      end
   end

   assign wen       = accept;
   assign waddr     = wbin_q[ADDR_WIDTH-1:0];
   assign wptr      = wptr_q;
   assign wfull     = wfull_q;
   assign woverflow = wovf_q;

`ifdef FIFO_WLEVEL_EN
   // Level uses the synchronised read pointer, so it lags reads and never under-reports.
   logic [PW-1:0] rbin_s;
   logic [PW-1:0] wlevel_q, wlevel_d;
   logic          wafull_q, wafull_d;

   always_comb begin
      rbin_s   = PW'(gray2bin(ptr_t'(rq2)));
      wlevel_d = wbin_d - rbin_s;
      wafull_d = (wlevel_d >= PW'(AFULL_THRESH));
   end

   always_ff @(posedge wclk) begin
      if (wrst) begin
         wlevel_q <= '0;
         wafull_q <= 1'b0;
      end else begin
         wlevel_q <= wlevel_d;
         wafull_q <= wafull_d;
      end
   end

   assign wlevel       = wlevel_q;
   assign walmost_full = wafull_q;
`else
   assign wlevel       = '0;
   assign walmost_full = 1'b0;
`endif

endmodule
